// File: rtl/scan_step_seq.sv
// scan_step_seq: scan-point sequencer on the dds clock.
// A rising edge of s_start launches a scan from one of two configuration
// sets (chosen by change). One scan_step pulse is issued per point, spaced
// dwell+1 cycles apart, followed by a single scan_done pulse. s_abort
// cancels a running scan without a done pulse.
module scan_step_seq #(
  parameter int IDX_W   = 8,
  parameter int DWELL_W = 16
) (
  input  logic               dds,
  input  logic               rst_n,
  input  logic               s_start,
  input  logic               s_abort,
  input  logic [1:0]         change,
  input  logic [IDX_W-1:0]   step_num1,
  input  logic [DWELL_W-1:0] dwell1,
  input  logic [IDX_W-1:0]   step_num2,
  input  logic [DWELL_W-1:0] dwell2,
  output logic               scan_busy,
  output logic               scan_step,
  output logic [IDX_W-1:0]   scan_idx,
  output logic               scan_done,
  output logic               scan_mode
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic               s_start_d;
  logic               rise;
  logic [IDX_W-1:0]   num_l;
  logic [DWELL_W-1:0] dwell_l;
  logic [IDX_W-1:0]   idx_cnt;
  logic [DWELL_W-1:0] dwell_cnt;

  logic [IDX_W-1:0]   sel_num;
  logic [DWELL_W-1:0] sel_dwell;
  logic               sel_ok;
  logic               last_pt;

  logic               launch;
  logic               dec_now;
  logic               step_now;
  logic               done_now;
  logic               abort_now;

  // Start edge, configuration set selection and last-point detection.
  assign rise      = s_start & ~s_start_d;
  assign sel_num   = change[0] ? step_num2 : step_num1;
  assign sel_dwell = change[0] ? dwell2 : dwell1;
  // change of 10/11 selects no set; a zero point count is not a scan.
  assign sel_ok    = ~change[1] && (sel_num != '0);
  assign last_pt   = (idx_cnt == (num_l - IDX_W'(1)));

  // State register.
  always_ff @(posedge dds or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-cycle action strobes; abort wins over step/done.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    dec_now   = 1'b0;
    step_now  = 1'b0;
    done_now  = 1'b0;
    abort_now = 1'b0;
    case (state)
      IDLE: begin
        if (rise && sel_ok && !s_abort) begin
          launch    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (s_abort) begin
          abort_now = 1'b1;
          state_nxt = IDLE;
        end else if (dwell_cnt != '0) begin
          dec_now = 1'b1;
        end else begin
          step_now = 1'b1;
          if (last_pt) begin
            state_nxt = FIN;
          end
        end
      end
      FIN: begin
        if (s_abort) begin
          abort_now = 1'b1;
        end else begin
          done_now = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counters, latched configuration and registered outputs.
  always_ff @(posedge dds or negedge rst_n) begin
    if (!rst_n) begin
      s_start_d <= 1'b0;
      num_l     <= '0;
      dwell_l   <= '0;
      idx_cnt   <= '0;
      dwell_cnt <= '0;
      scan_busy <= 1'b0;
      scan_step <= 1'b0;
      scan_idx  <= '0;
      scan_done <= 1'b0;
      scan_mode <= 1'b0;
    end else begin
      s_start_d <= s_start;
      scan_step <= 1'b0;
      scan_done <= 1'b0;
      if (launch) begin
        num_l     <= sel_num;
        dwell_l   <= sel_dwell;
        scan_mode <= change[0];
        idx_cnt   <= '0;
        dwell_cnt <= sel_dwell;
        scan_busy <= 1'b1;
      end
      if (abort_now) begin
        scan_busy <= 1'b0;
      end
      if (dec_now) begin
        dwell_cnt <= dwell_cnt - DWELL_W'(1);
      end
      if (step_now) begin
        scan_step <= 1'b1;
        scan_idx  <= idx_cnt;
        // On the last point the counters are left as-is; FIN follows.
        if (!last_pt) begin
          idx_cnt   <= idx_cnt + IDX_W'(1);
          dwell_cnt <= dwell_l;
        end
      end
      if (done_now) begin
        scan_done <= 1'b1;
        scan_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scan_step_seq.sv
// Bench for scan_step_seq: directed scenarios followed by a randomized
// phase, all compared cycle by cycle against a timeline model of the scan.
module tb_scan_step_seq;

  localparam int IDX_W   = 8;
  localparam int DWELL_W = 16;

  logic               dds = 1'b0;
  logic               rst_n = 1'b0;
  logic               s_start = 1'b0;
  logic               s_abort = 1'b0;
  logic [1:0]         change = 2'b00;
  logic [IDX_W-1:0]   step_num1 = '0;
  logic [DWELL_W-1:0] dwell1 = '0;
  logic [IDX_W-1:0]   step_num2 = '0;
  logic [DWELL_W-1:0] dwell2 = '0;
  logic               scan_busy;
  logic               scan_step;
  logic [IDX_W-1:0]   scan_idx;
  logic               scan_done;
  logic               scan_mode;

  scan_step_seq #(.IDX_W(IDX_W), .DWELL_W(DWELL_W)) dut (
    .dds       (dds),
    .rst_n     (rst_n),
    .s_start   (s_start),
    .s_abort   (s_abort),
    .change    (change),
    .step_num1 (step_num1),
    .dwell1    (dwell1),
    .step_num2 (step_num2),
    .dwell2    (dwell2),
    .scan_busy (scan_busy),
    .scan_step (scan_step),
    .scan_idx  (scan_idx),
    .scan_done (scan_done),
    .scan_mode (scan_mode)
  );

  always #5 dds = ~dds;

  int n_tests = 0;
  int n_fail  = 0;

  // Timeline model: a scan launched at edge k with n points and dwell d
  // steps at edges k + j*(d+1), j = 1..n, and completes at k + n*(d+1) + 1.
  int  edge_n   = 0;
  bit  m_active = 0;
  int  m_k      = 0;
  int  m_n      = 0;
  int  m_d      = 0;
  bit  m_prev   = 0;
  bit  m_busy   = 0;
  bit  m_step   = 0;
  bit  m_done   = 0;
  bit  m_mode   = 0;
  int  m_idx    = 0;

  // Observed activity since the last clear_stats.
  int steps_seen = 0;
  int done_seen  = 0;
  int busy_seen  = 0;
  int first_idx  = -1;
  int last_idx   = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    steps_seen = 0;
    done_seen  = 0;
    busy_seen  = 0;
    first_idx  = -1;
    last_idx   = -1;
  endtask

  task automatic model_reset();
    m_active = 0;
    m_prev   = 0;
    m_busy   = 0;
    m_step   = 0;
    m_done   = 0;
    m_mode   = 0;
    m_idx    = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, 32'(scan_busy), 32'd0);
    check({tag, ".step"}, 32'(scan_step), 32'd0);
    check({tag, ".idx"},  32'(scan_idx),  32'd0);
    check({tag, ".done"}, 32'(scan_done), 32'd0);
    check({tag, ".mode"}, 32'(scan_mode), 32'd0);
  endtask

  // Advance one clock: predict from the inputs present at the edge, then compare.
  task automatic tick();
    bit rise;
    int t;
    int num;
    edge_n++;
    rise   = s_start && !m_prev;
    m_prev = s_start;
    m_step = 0;
    m_done = 0;
    if (m_active) begin
      t = edge_n - m_k;
      if (s_abort) begin
        m_active = 0;
        m_busy   = 0;
      end else if (t == m_n * (m_d + 1) + 1) begin
        m_done   = 1;
        m_busy   = 0;
        m_active = 0;
      end else if (t % (m_d + 1) == 0) begin
        m_step = 1;
        m_idx  = t / (m_d + 1) - 1;
      end
    end else begin
      num = change[0] ? int'(step_num2) : int'(step_num1);
      if (rise && !change[1] && num != 0 && !s_abort) begin
        m_active = 1;
        m_k      = edge_n;
        m_n      = num;
        m_d      = change[0] ? int'(dwell2) : int'(dwell1);
        m_mode   = change[0];
        m_busy   = 1;
      end
    end
    @(posedge dds);
    #1;
    check("busy", 32'(scan_busy), 32'(m_busy));
    check("step", 32'(scan_step), 32'(m_step));
    check("idx",  32'(scan_idx),  32'(m_idx));
    check("done", 32'(scan_done), 32'(m_done));
    check("mode", 32'(scan_mode), 32'(m_mode));
    if (scan_step) begin
      if (steps_seen == 0) first_idx = int'(scan_idx);
      last_idx = int'(scan_idx);
      steps_seen++;
    end
    if (scan_done) done_seen++;
    if (scan_busy) busy_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
  endtask

  initial begin
    // Reset state.
    #12;
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    model_reset();
    run(3);

    // Basic scan: 4 points, dwell 3.
    change = 2'b00; step_num1 = 8'd4; dwell1 = 16'd3;
    clear_stats();
    pulse_start();
    run(20);
    check("basic.steps", 32'(steps_seen), 32'd4);
    check("basic.last_idx", 32'(last_idx), 32'd3);
    check("basic.done", 32'(done_seen), 32'd1);
    check("basic.busy_cycles", 32'(busy_seen), 32'd17);
    check("basic.mode", 32'(scan_mode), 32'd0);

    // Scale 2 with zero dwell.
    change = 2'b01; step_num2 = 8'd3; dwell2 = 16'd0;
    clear_stats();
    pulse_start();
    run(6);
    check("s2.steps", 32'(steps_seen), 32'd3);
    check("s2.done", 32'(done_seen), 32'd1);
    check("s2.mode", 32'(scan_mode), 32'd1);

    // Ignored start A: change = 10, s_start held for 5 cycles.
    change = 2'b10; step_num1 = 8'd4; step_num2 = 8'd4;
    clear_stats();
    s_start = 1'b1;
    run(5);
    s_start = 1'b0;
    run(3);
    check("ignA.busy", 32'(busy_seen), 32'd0);
    check("ignA.steps", 32'(steps_seen), 32'd0);
    // Ignored start B: zero point count.
    change = 2'b00; step_num1 = 8'd0;
    clear_stats();
    pulse_start();
    run(5);
    check("ignB.busy", 32'(busy_seen), 32'd0);
    check("ignB.pulses", 32'(steps_seen + done_seen), 32'd0);

    // Mid-scan changes and re-start are ignored.
    change = 2'b00; step_num1 = 8'd5; dwell1 = 16'd2;
    clear_stats();
    pulse_start();
    run(6);
    change = 2'b01; step_num1 = 8'd2; dwell1 = 16'd7; step_num2 = 8'd9; dwell2 = 16'd1;
    pulse_start();
    run(12);
    check("mid.steps", 32'(steps_seen), 32'd5);
    check("mid.last_idx", 32'(last_idx), 32'd4);
    check("mid.done", 32'(done_seen), 32'd1);

    // Abort on the cycle of the 3rd step.
    change = 2'b00; step_num1 = 8'd6; dwell1 = 16'd2;
    clear_stats();
    pulse_start();
    run(8);
    s_abort = 1'b1;
    tick();
    s_abort = 1'b0;
    check("abort.idx", 32'(scan_idx), 32'd1);
    check("abort.busy", 32'(scan_busy), 32'd0);
    run(20);
    check("abort.steps", 32'(steps_seen), 32'd2);
    check("abort.done", 32'(done_seen), 32'd0);
    clear_stats();
    pulse_start();
    run(20);
    check("restart.first_idx", 32'(first_idx), 32'd0);
    check("restart.steps", 32'(steps_seen), 32'd6);

    // Largest point count with zero dwell.
    change = 2'b00; step_num1 = 8'd255; dwell1 = 16'd0;
    clear_stats();
    pulse_start();
    run(258);
    check("max.steps", 32'(steps_seen), 32'd255);
    check("max.last_idx", 32'(last_idx), 32'd254);
    check("max.done", 32'(done_seen), 32'd1);

    // Asynchronous reset in the middle of a dwell.
    change = 2'b01; step_num2 = 8'd4; dwell2 = 16'd5;
    pulse_start();
    run(3);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge dds);
    #1;
    check_all_zero("rst_hold");
    #2 rst_n = 1'b1;
    clear_stats();
    run(10);
    check("post_rst.busy", 32'(busy_seen), 32'd0);

    // Release reset with s_start already high: launch on the first clock.
    #2 rst_n = 1'b0;
    model_reset();
    change = 2'b00; step_num1 = 8'd2; dwell1 = 16'd1;
    s_start = 1'b1;
    #3 rst_n = 1'b1;
    clear_stats();
    tick();
    check("rst_launch.busy", 32'(scan_busy), 32'd1);
    run(3);
    s_start = 1'b0;
    run(4);
    check("rst_launch.steps", 32'(steps_seen), 32'd2);
    check("rst_launch.done", 32'(done_seen), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      s_start   = ($urandom_range(3, 0) == 0);
      s_abort   = ($urandom_range(39, 0) == 0);
      change    = ($urandom_range(4, 0) == 0) ? 2'($urandom_range(3, 2)) : 2'($urandom_range(1, 0));
      step_num1 = 8'($urandom_range(6, 0));
      step_num2 = 8'($urandom_range(6, 0));
      dwell1    = 16'($urandom_range(3, 0));
      dwell2    = 16'($urandom_range(3, 0));
      tick();
    end
    s_start = 1'b0;
    s_abort = 1'b0;
    run(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
